// File: rtl/controlador_execucao.sv
// controlador_execucao: step/continuous execution controller for a simple
// processor. A raw pushbutton (KeyStep) is synchronised and debounced; its
// filtered rising edge starts one instruction (single-step) or a run of
// instructions (continuous) by raising Run until the processor reports Done.
//
// Optional feature, enabled by defining the macro CTRL_WATCHDOG_EN:
//   an EXEC-cycle watchdog that raises a sticky Fault and forces IDLE when
//   the processor fails to report Done within WDOG_CYCLES cycles.
//   With the macro undefined, Fault is tied low and EXEC waits forever.
//
// Handshake: there is no valid/ready pair here. Done is a one-cycle pulse
// that is only meaningful while Run is high (state EXEC); it is ignored in
// every other state and never queued. StepReq is likewise consumed only in
// IDLE and dropped anywhere else.
//
// dbg_state exposes the FSM encoding (0 IDLE, 1 EXEC, 2 WAIT_REL) for
// checkers and waveform inspection.

module controlador_execucao #(
    parameter int DEB_CYCLES  = 16,
    parameter int WDOG_CYCLES = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        KeyStep,
    input  logic        ModeCont,
    input  logic        Halt,
    input  logic        Done,
    output logic        Run,
    output logic        Busy,
    output logic [15:0] InstrCount,
    output logic        Fault,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    // Counter compares against N-1 because the flip happens on the edge that
    // observes the N-th consecutive disagreeing cycle.
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    // Reject parameter values the 8-bit counters cannot represent.
    if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_deb_range
        $error("controlador_execucao: DEB_CYCLES out of range 2..255");
    end
    if (WDOG_CYCLES < 8 || WDOG_CYCLES > 255) begin : g_wdog_range
        $error("controlador_execucao: WDOG_CYCLES out of range 8..255");
    end

    // ------------------------------------------------------------------
    // Key conditioning
    // ------------------------------------------------------------------
    logic       key_meta;
    logic       key_sync;
    logic [7:0] deb_cnt;
    logic       key_filt;
    logic       key_filt_d;
    logic       step_req;

    // Two-flop synchroniser for the asynchronous pushbutton.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
        end else begin
            key_meta <= KeyStep;
            key_sync <= key_meta;
        end
    end

    // Debounce: flip the filtered level only after DEB_CYCLES consecutive
    // disagreeing samples; a single agreeing sample restarts the count.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            deb_cnt  <= 8'd0;
            key_filt <= 1'b0;
        end else if (key_sync == key_filt) begin
            deb_cnt <= 8'd0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt  <= 8'd0;
            key_filt <= ~key_filt;
        end else begin
            deb_cnt <= deb_cnt + 8'd1;
        end
    end

    // One-cycle registered step request on the filtered rising edge only.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            key_filt_d <= 1'b0;
            step_req   <= 1'b0;
        end else begin
            key_filt_d <= key_filt;
            step_req   <= key_filt & ~key_filt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t state_d;
    logic   halt_latch;
    logic   wdog_trip;
    logic   step_ok;

`ifdef CTRL_WATCHDOG_EN
    localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

    logic [7:0] wdog_cnt;
    logic       fault_q;

    // Trip on the edge that closes the WDOG_CYCLES-th EXEC cycle without Done.
    assign wdog_trip = (state == EXEC) && !Done && (wdog_cnt == WDOG_LAST);

    // Count consecutive EXEC cycles without Done; restart on Done or exit.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wdog_cnt <= 8'd0;
        end else if (state != EXEC || Done || wdog_trip) begin
            wdog_cnt <= 8'd0;
        end else begin
            wdog_cnt <= wdog_cnt + 8'd1;
        end
    end

    // Sticky fault flag; only Reset clears it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            fault_q <= 1'b0;
        end else if (wdog_trip) begin
            fault_q <= 1'b1;
        end
    end

    assign Fault   = fault_q;
    assign step_ok = step_req & ~fault_q;
`else
    assign wdog_trip = 1'b0;
    assign Fault     = 1'b0;
    assign step_ok   = step_req;
`endif

    // State register; reset forces IDLE so Run drops without a clock edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic. Halt never cuts an instruction short: it only
    // redirects the transition taken when Done arrives.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (step_ok) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (wdog_trip) begin
                    state_d = IDLE;
                end else if (Done) begin
                    if (halt_latch || Halt) begin
                        state_d = IDLE;
                    end else if (!ModeCont) begin
                        state_d = WAIT_REL;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            WAIT_REL: begin
                if (!key_filt) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Remember a Halt seen during EXEC until the run ends in IDLE.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            halt_latch <= 1'b0;
        end else if (state_d == IDLE && state != IDLE) begin
            halt_latch <= 1'b0;
        end else if (state == EXEC && Halt) begin
            halt_latch <= 1'b1;
        end
    end

    // Instruction counter: only Done pulses seen in EXEC count; wraps at 16 bits.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            InstrCount <= 16'd0;
        end else if (state == EXEC && Done) begin
            InstrCount <= InstrCount + 16'd1;
        end
    end

    assign Run       = (state == EXEC);
    assign Busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: doc/controlador_execucao.md
CONTROLADOR_EXECUCAO -- requirements
Module: controlador_execucao

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, meaning the number of consecutive stable synchronized cycles before KeyStep is accepted (legal range 2..255).
REQ-002 SHALL have parameter WDOG_CYCLES, default 255, meaning the number of EXEC cycles without Done before a watchdog fault (legal range 8..255).
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all flops sample on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port KeyStep, input, 1 bit: raw asynchronous pushbutton, active-high.
REQ-006 SHALL have port ModeCont, input, 1 bit: 0 selects single-step, 1 selects continuous execution.
REQ-007 SHALL have port Halt, input, 1 bit: request to stop continuous execution.
REQ-008 SHALL have port Done, input, 1 bit: one-cycle pulse from the processor marking the end of an instruction.
REQ-009 SHALL have port Run, output, 1 bit: drives the processor's Run input.
REQ-010 SHALL have port Busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have port InstrCount, output, 16 bits: count of accepted Done pulses.
REQ-012 SHALL have port Fault, output, 1 bit: sticky watchdog fault flag.

Function
REQ-013 SHALL pass KeyStep through a 2-flop synchronizer, then a debounce filter.
REQ-014 Debounce filter: the filtered level SHALL change only after the synchronized value differs from it for DEB_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-015 A filtered rising edge SHALL produce exactly one registered StepReq pulse, one cycle wide; a filtered falling edge SHALL produce no pulse.
REQ-016 FSM states SHALL be IDLE, EXEC and WAIT_REL, with Run = 1 only in EXEC.
REQ-017 In IDLE, StepReq SHALL move the FSM to EXEC; Halt and Done SHALL be ignored in IDLE.
REQ-018 With KeyStep held stable high, Run SHALL first be high exactly DEB_CYCLES+3 rising edges after the first edge that samples KeyStep high.
REQ-019 In EXEC, Done = 1 SHALL increment InstrCount by 1 on the same edge; 0xFFFF SHALL wrap to 0x0000.
REQ-020 In EXEC with Done = 1 and ModeCont = 0, the FSM SHALL go to WAIT_REL, so Run is low the following cycle.
REQ-021 In EXEC with Done = 1, ModeCont = 1 and HaltLatch = 0, the FSM SHALL stay in EXEC.
REQ-022 HaltLatch SHALL be set by Halt = 1 in any EXEC cycle and cleared on entry to IDLE.
REQ-023 In EXEC with Done = 1 and (HaltLatch = 1 or Halt = 1), the FSM SHALL go to IDLE, so the current instruction always completes.
REQ-024 In WAIT_REL, the FSM SHALL return to IDLE when the filtered key is low; a key still held SHALL NOT start another step.
REQ-025 Done while not in EXEC SHALL be ignored and SHALL NOT be counted.
REQ-026 A ModeCont change during EXEC SHALL take effect at the next Done.
REQ-027 StepReq occurring in EXEC or WAIT_REL SHALL be discarded, not queued.

Reset
REQ-028 Reset = 1 SHALL force, asynchronously, state = IDLE, Run = 0, Busy = 0, InstrCount = 0, Fault = 0, HaltLatch = 0, synchronizer flops = 0, filtered level = 0, and debounce counter = 0.
REQ-029 Reset asserted mid-EXEC SHALL drop Run immediately, without waiting for a clock edge.
REQ-030 After Reset deasserts, a key already held high SHALL be treated as a fresh press after debounce.

Configuration
REQ-031 With macro CTRL_WATCHDOG_EN defined, an 8-bit counter SHALL count consecutive EXEC cycles without Done and clear on Done or on leaving EXEC.
REQ-032 With CTRL_WATCHDOG_EN defined, reaching WDOG_CYCLES SHALL set Fault, force IDLE and drop Run on the next edge.
REQ-033 With CTRL_WATCHDOG_EN defined, StepReq SHALL be ignored while Fault = 1; only Reset clears Fault.
REQ-034 Without CTRL_WATCHDOG_EN, Fault SHALL be tied to 0, no watchdog logic SHALL exist, and EXEC SHALL wait for Done indefinitely.

Verification (DEB_CYCLES = 4)
REQ-035 Single-step: with ModeCont = 0, KeyStep high from edge 0, Done pulses 3 cycles after Run rises -> Run high at edges 7..9 (inclusive), InstrCount = 1, Run stays low until the key is released and pressed again.
REQ-036 Bounce: KeyStep toggles every cycle for 20 cycles, then stays low -> Run is never asserted and InstrCount = 0.
REQ-037 Continuous with Halt: ModeCont = 1, one press, Done every 4 cycles, Halt pulsed between the 5th and 6th Done -> InstrCount = 6, Run low the cycle after the 6th Done, state IDLE.
REQ-038 Wrap and spurious Done: InstrCount preloaded to 0xFFFF by 65535 Dones, one more Done -> 0x0000; a Done pulse in IDLE -> count unchanged.
REQ-039 Reset mid-EXEC: Reset raised between clock edges while Run = 1 -> Run = 0 before the next edge, and InstrCount = 0.
REQ-040 Watchdog (macro defined, WDOG_CYCLES = 8): press with no Done -> Fault = 1 and Run = 0 after 8 EXEC cycles; a further press is ignored until Reset.
